voice_allocator: RTL and testbench
==================================

# voice_allocator

Polyphonic voice allocator that shares a bank of `NUM_VOICES` synth channels between a single stream of note-on/note-off events. It sits between the note-event source (MIDI decoder or sequencer) and the channel instances. For each channel it drives the `pitch`, `waveform` and `ena` inputs. On overflow it steals the oldest voice. Pitch codes pass through unchanged: `pitch = clk/(2*256*freq) - 1`.

## Interface
- `NUM_VOICES`, default 4: number of channels managed; power of two, range 2..8.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-low reset; reset asserted when `rst == 0` at a `clk` posedge.
- `ev_valid`  in  1  event present.
- `ev_ready`  out  1  allocator can accept an event.
- `ev_on`  in  1  1 = note-on, 0 = note-off.
- `ev_pitch`  in  12  channel pitch code of the event.
- `ev_wave`  in  2  waveform for note-on (0 square, 1 triangle, 2 sine, 3 saw); ignored on note-off.
- `all_off`  in  1  panic: silence every voice.
- `v_pitch`  out  12*NUM_VOICES  per-voice pitch, voice i at `[12i+11:12i]`.
- `v_wave`  out  2*NUM_VOICES  per-voice waveform.
- `v_ena`  out  NUM_VOICES  per-voice enable (channel `ena`).
- `steal`  out  1  one-cycle pulse when a note-on evicted an active voice.

## Operation
- **Per-voice state**
  - `pitch` (12 bit), `wave` (2 bit), `active` (1 bit).
  - `rank` (log2 NUM_VOICES bits): rank 0 is newest. Ranks always form a permutation of 0..NUM_VOICES-1.
- **FSM**
  - **IDLE**: `ev_ready = 1`. On `ev_valid && ev_ready`, latch `ev_on`/`ev_pitch`/`ev_wave` and go to MATCH.
  - **MATCH**: `ev_ready = 0`. Compute the target voice, then go to APPLY.
  - **APPLY**: `ev_ready = 0`. Update voice state, then go to IDLE.
- **Note-on target selection**, in priority order:
  - An active voice whose pitch equals `ev_pitch`: retrigger. Update `wave`, no steal.
  - Otherwise, the lowest-index inactive voice.
  - Otherwise, the active voice with the highest rank: steal, and pulse `steal` in APPLY.
- **Note-on apply**:
  - Target gets `pitch`, `wave`, `active = 1` and `rank = 0`.
  - Every voice whose rank was below the target's old rank increments its rank. All other ranks are unchanged.
- **Note-off**:
  - The active voice whose pitch matches is set to `active = 0`. Its `pitch`, `wave` and `rank` are kept.
  - If no active voice matches, nothing changes.
  - Duplicate pitches cannot exist, because note-on retriggers on a match.
- **Outputs**: `v_pitch`, `v_wave` and `v_ena` are registered copies of the voice state. `v_ena[i] = active[i]`.
- **`all_off`**:
  - Sampled every cycle and takes priority over everything else.
  - Clears all `active` bits and returns the FSM to IDLE.
  - Any event in MATCH or APPLY is dropped.
  - An event offered in the same cycle as `all_off` is not accepted (`ev_ready` is forced to 0 that cycle).
  - Ranks, pitches and waves are untouched.
- **Reset** (`rst == 0`):
  - `active = 0`, `pitch = 0`, `wave = 0`, `rank[i] = i`, FSM in IDLE.
  - `ev_ready = 0` and `steal = 0` during reset.
- **Reset mid-operation**: the pending event is discarded.

## Timing
- Event accepted at posedge N. MATCH occupies cycle N+1 and APPLY cycle N+2. Outputs reflect the event after posedge N+3.
- `steal` is high during the cycle following the APPLY edge, for exactly one cycle.
- Maximum throughput is one event per 3 cycles. `ev_ready` is high only in IDLE.
- `ev_ready` is combinational from FSM state and `all_off`; there is no combinational path from `ev_valid`.
- `all_off` asserted at posedge N: `v_ena = 0` after posedge N+1, and the FSM is in IDLE with `ev_ready = 1` in cycle N+1 if `all_off` is low by then.
- First cycle with `rst == 1` after reset: `ev_ready = 1`.

## Test plan
- **Reset**: hold `rst = 0` for 2 cycles with `ev_valid = 1` -> all outputs 0, `ev_ready = 0`, nothing accepted. Release -> `ev_ready = 1` next cycle.
- **Fill, NUM_VOICES=4**: note-on pitches 52, 26, 100, 200, all with wave 0 -> voices 0..3 active with those pitches in order. Each update lands 3 cycles after acceptance. `steal` never pulses.
- **Steal**: after the fill, note-on 300 with wave 3 -> voice 0 (oldest, rank 3) becomes pitch 300, wave 3. `steal` pulses once. Ranks become v0=0, v1=3, v2=2, v3=1.
- **Retrigger and release**:
  - Note-on 26 with wave 2 -> voice 1 wave becomes 2, no steal.
  - Note-off 100 -> `v_ena[2] = 0`, `v_pitch[2]` stays 100.
  - Note-on 400 -> reuses voice 2.
  - Note-off 999 -> no change.
- **Panic**: assert `all_off` the cycle after a note-on is accepted -> `v_ena = 0`, the event is dropped, and `ev_ready = 1` once `all_off` deasserts.
- **Back-to-back**: hold `ev_valid = 1` for 12 cycles -> exactly 4 events accepted, one every 3 cycles.

Source files
------------

// File: rtl/voice_allocator.sv
// -----------------------------------------------------------------------------
// voice_allocator
//
// Shares NUM_VOICES synth channels between one stream of note-on/note-off
// events. Every event passes through a three-state pipeline:
// IDLE (accept) -> MATCH (pick target voice) -> APPLY (update voice state).
// A note-on retriggers a voice that already plays the same pitch. Otherwise it
// takes the lowest-index free voice. If no voice is free, it steals the oldest
// voice. A note-off releases the voice that plays its pitch. Voice age is kept
// as a rank permutation, where rank 0 is the newest voice.
//
// Ports
//   clk       in   system clock
//   rst       in   synchronous reset, active low
//   ev_valid  in   event present
//   ev_ready  out  event accepted when ev_valid && ev_ready (IDLE only)
//   ev_on     in   1 = note-on, 0 = note-off
//   ev_pitch  in   12-bit channel pitch code (passed through unchanged)
//   ev_wave   in   waveform for note-on (0 sq, 1 tri, 2 sine, 3 saw)
//   all_off   in   panic: silence all voices and drop any pending event
//   v_pitch   out  per-voice pitch, voice i at [12i+11:12i]
//   v_wave    out  per-voice waveform, voice i at [2i+1:2i]
//   v_ena     out  per-voice channel enable
//   steal     out  one-cycle pulse while a stealing note-on is in APPLY
// -----------------------------------------------------------------------------
module voice_allocator #(
  parameter int NUM_VOICES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ev_valid,
  output logic                       ev_ready,
  input  logic                       ev_on,
  input  logic [11:0]                ev_pitch,
  input  logic [1:0]                 ev_wave,
  input  logic                       all_off,
  output logic [12*NUM_VOICES-1:0]   v_pitch,
  output logic [2*NUM_VOICES-1:0]    v_wave,
  output logic [NUM_VOICES-1:0]      v_ena,
  output logic                       steal
);

  localparam int RW = $clog2(NUM_VOICES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MATCH,
    ST_APPLY
  } state_t;

  state_t state_q, state_d;

  // Latched event
  logic          ev_on_q;
  logic [11:0]   ev_pitch_q;
  logic [1:0]    ev_wave_q;

  // Target chosen in MATCH and consumed in APPLY
  logic [RW-1:0] tgt_q;
  logic          tgt_hit_q;

  // Voice state
  logic [11:0]           pitch_q [NUM_VOICES];
  logic [1:0]            wave_q  [NUM_VOICES];
  logic [RW-1:0]         rank_q  [NUM_VOICES];
  logic [NUM_VOICES-1:0] active_q;

  // Target selection, evaluated from the latched event
  logic          match_any, free_any;
  logic [RW-1:0] match_idx, free_idx, oldest_idx;
  logic          sel_hit, sel_steal;
  logic [RW-1:0] sel_tgt;

  logic          accept;
  logic [RW-1:0] old_rank;

  // ---------------------------------------------------------------------------
  // FSM next state and handshake.
  // ev_ready depends only on state, all_off and rst. It never depends on
  // ev_valid. rst gates it so that ev_ready stays low while reset is held.
  // ---------------------------------------------------------------------------
  // NOTE: every signal in a combinational block gets a default value first.
  // Otherwise a path that does not assign it infers a latch.
  always_comb begin
    state_d  = state_q;
    ev_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ev_ready = rst && !all_off;
        if (ev_valid && ev_ready) state_d = ST_MATCH;
      end
      ST_MATCH: state_d = ST_APPLY;
      ST_APPLY: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign accept = ev_valid && ev_ready;

  // ---------------------------------------------------------------------------
  // Target search. The loop runs from the top index down, so the last hit
  // written wins and lowest-index priority comes out naturally. Exactly one
  // voice holds rank NUM_VOICES-1, because ranks are a permutation.
  // ---------------------------------------------------------------------------
  always_comb begin
    match_any  = 1'b0;
    match_idx  = '0;
    free_any   = 1'b0;
    free_idx   = '0;
    oldest_idx = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (active_q[i] && (pitch_q[i] == ev_pitch_q)) begin
        match_any = 1'b1;
        match_idx = RW'(i);
      end
      if (!active_q[i]) begin
        free_any = 1'b1;
        free_idx = RW'(i);
      end
      if (rank_q[i] == RW'(NUM_VOICES - 1)) oldest_idx = RW'(i);
    end

    sel_hit   = 1'b0;
    sel_tgt   = '0;
    sel_steal = 1'b0;
    if (ev_on_q) begin
      sel_hit = 1'b1;
      if (match_any) begin
        sel_tgt = match_idx;             // retrigger the same pitch
      end else if (free_any) begin
        sel_tgt = free_idx;
      end else begin
        sel_tgt   = oldest_idx;          // evict the oldest voice
        sel_steal = 1'b1;
      end
    end else begin
      sel_hit = match_any;               // a note-off with no match does nothing
      sel_tgt = match_idx;
    end
  end

  assign old_rank = rank_q[tgt_q];

  // ---------------------------------------------------------------------------
  // State registers. all_off comes right after reset in priority: it clears
  // every active bit and drops the event in flight. It leaves pitch, wave and
  // rank untouched.
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments only. Every register
  // then samples pre-edge values, so the rank shuffle reads consistent old ranks.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      ev_on_q    <= 1'b0;
      ev_pitch_q <= '0;
      ev_wave_q  <= '0;
      tgt_q      <= '0;
      tgt_hit_q  <= 1'b0;
      steal      <= 1'b0;
      active_q   <= '0;
      // NOTE: the voice table is a handful of flops, not a RAM, so it is reset
      // explicitly. The ranks must start as a valid permutation (rank[i] = i).
      for (int i = 0; i < NUM_VOICES; i++) begin
        pitch_q[i] <= '0;
        wave_q[i]  <= '0;
        rank_q[i]  <= RW'(i);
      end
    end else if (all_off) begin
      state_q   <= ST_IDLE;
      tgt_hit_q <= 1'b0;
      steal     <= 1'b0;
      active_q  <= '0;
    end else begin
      state_q <= state_d;

      if (accept) begin
        ev_on_q    <= ev_on;
        ev_pitch_q <= ev_pitch;
        ev_wave_q  <= ev_wave;
      end

      // steal is high for the single cycle spent in APPLY
      steal <= (state_q == ST_MATCH) && sel_steal;

      if (state_q == ST_MATCH) begin
        tgt_q     <= sel_tgt;
        tgt_hit_q <= sel_hit;
      end

      if ((state_q == ST_APPLY) && tgt_hit_q) begin
        if (ev_on_q) begin
          pitch_q[tgt_q]  <= ev_pitch_q;
          wave_q[tgt_q]   <= ev_wave_q;
          active_q[tgt_q] <= 1'b1;
          // Target becomes newest. Voices newer than the target age by one.
          // Older voices keep their rank, so the ranks stay a permutation.
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (RW'(i) == tgt_q) begin
              rank_q[i] <= '0;
            end else if (rank_q[i] < old_rank) begin
              rank_q[i] <= rank_q[i] + RW'(1);
            end
          end
        end else begin
          active_q[tgt_q] <= 1'b0;       // release, keep pitch/wave/rank
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered copies of the voice table drive the channel inputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      v_pitch <= '0;
      v_wave  <= '0;
      v_ena   <= '0;
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        v_pitch[12*i +: 12] <= pitch_q[i];
        v_wave[2*i +: 2]    <= wave_q[i];
      end
      v_ena <= active_q;
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// -----------------------------------------------------------------------------
// tb_voice_allocator
//
// Self-checking bench for voice_allocator with NUM_VOICES = 4. A monitor
// tracks accepted events and runs a behavioural voice model. It pushes the
// expected outputs when an event reaches APPLY and pops them when the outputs
// are due. Directed checks cover the reset, fill, steal, retrigger/release,
// panic and back-to-back scenarios.
// -----------------------------------------------------------------------------
module tb_voice_allocator;

  localparam int NV = 4;
  localparam int PW = 12 * NV;
  localparam int WW = 2 * NV;

  logic          clk = 1'b0;
  logic          rst;
  logic          ev_valid;
  logic          ev_ready;
  logic          ev_on;
  logic [11:0]   ev_pitch;
  logic [1:0]    ev_wave;
  logic          all_off;
  logic [PW-1:0] v_pitch;
  logic [WW-1:0] v_wave;
  logic [NV-1:0] v_ena;
  logic          steal;

  voice_allocator #(.NUM_VOICES(NV)) dut (
    .clk      (clk),
    .rst      (rst),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_on    (ev_on),
    .ev_pitch (ev_pitch),
    .ev_wave  (ev_wave),
    .all_off  (all_off),
    .v_pitch  (v_pitch),
    .v_wave   (v_wave),
    .v_ena    (v_ena),
    .steal    (steal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural voice model
  // ---------------------------------------------------------------------------
  int m_pitch  [NV];
  int m_wave   [NV];
  int m_rank   [NV];
  bit m_active [NV];

  function automatic void model_reset();
    for (int i = 0; i < NV; i++) begin
      m_pitch[i] = 0; m_wave[i] = 0; m_rank[i] = i; m_active[i] = 0;
    end
  endfunction

  // Returns the target voice or -1. stl is set when a voice is evicted.
  function automatic int model_pick(input bit on, input int p, output bit stl);
    int t;
    t   = -1;
    stl = 0;
    for (int i = 0; i < NV; i++)
      if (t < 0 && m_active[i] && m_pitch[i] == p) t = i;
    if (on && t < 0)
      for (int i = 0; i < NV; i++)
        if (t < 0 && !m_active[i]) t = i;
    if (on && t < 0)
      for (int i = 0; i < NV; i++)
        if (t < 0 && m_rank[i] == NV - 1) begin t = i; stl = 1; end
    return t;
  endfunction

  function automatic void model_apply(input bit on, input int p, input int w);
    int t, old;
    bit stl;
    t = model_pick(on, p, stl);
    if (t < 0) return;
    if (on) begin
      old = m_rank[t];
      for (int i = 0; i < NV; i++)
        if (i != t && m_rank[i] < old) m_rank[i] = m_rank[i] + 1;
      m_rank[t] = 0; m_pitch[t] = p; m_wave[t] = w; m_active[t] = 1;
    end else begin
      m_active[t] = 0;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard monitor (samples on the falling edge)
  // ---------------------------------------------------------------------------
  typedef struct {
    int            due;
    logic [PW-1:0] p;
    logic [WW-1:0] w;
    logic [NV-1:0] e;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  bit   inf_valid = 0;
  int   inf_acc, inf_pitch, inf_wave;
  bit   inf_on;
  int   panic_due = -1;
  int   accept_cnt = 0;
  int   steal_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    bit   exp_st, st;
    exp_t ex, pk;
    if (!rst) begin
      exp_q.delete();
      inf_valid = 0;
      panic_due = -1;
      model_reset();
    end else begin
      // steal is expected in the APPLY cycle of an evicting note-on
      exp_st = 0;
      if (inf_valid && inf_acc + 1 == cyc) begin
        void'(model_pick(inf_on, inf_pitch, st));
        exp_st = st;
      end
      check("steal", steal, exp_st);
      if (steal) steal_cnt++;

      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        ex = exp_q.pop_front();
        check("v_pitch", v_pitch, ex.p);
        check("v_wave", v_wave, ex.w);
        check("v_ena", v_ena, ex.e);
      end

      if (panic_due == cyc) check("panic_ena", v_ena, 0);

      if (all_off) begin
        inf_valid = 0;
        for (int i = 0; i < NV; i++) m_active[i] = 0;
        panic_due = cyc + 2;
      end else if (inf_valid && inf_acc + 1 == cyc) begin
        model_apply(inf_on, inf_pitch, inf_wave);
        pk.due = cyc + 2;
        for (int i = 0; i < NV; i++) begin
          pk.p[12*i +: 12] = 12'(m_pitch[i]);
          pk.w[2*i +: 2]   = 2'(m_wave[i]);
          pk.e[i]          = m_active[i];
        end
        exp_q.push_back(pk);
        inf_valid = 0;
      end

      if (ev_valid && ev_ready) begin
        inf_valid = 1;
        inf_acc   = cyc + 1;
        inf_on    = ev_on;
        inf_pitch = int'(ev_pitch);
        inf_wave  = int'(ev_wave);
        accept_cnt++;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  // Offer one event, wait (bounded) for it to be accepted, then wait until
  // its outputs are due (the falling edge after the third edge past acceptance).
  task automatic send_wait(input bit on, input int p, input int w);
    int n;
    @(posedge clk); #1;
    ev_valid = 1; ev_on = on; ev_pitch = 12'(p); ev_wave = 2'(w);
    n = 0;
    @(negedge clk);
    while (!ev_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!ev_ready) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    ev_valid = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int got, acc_before;
    bit a;
    logic [PW-1:0] pv;

    // Reset with an event offered
    rst = 0; ev_valid = 1; ev_on = 1; ev_pitch = 12'd77; ev_wave = 0; all_off = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", ev_ready, 0);
    check("rst_pitch", v_pitch, 0);
    check("rst_wave", v_wave, 0);
    check("rst_ena", v_ena, 0);
    check("rst_steal", steal, 0);
    @(posedge clk); #1;
    rst = 1; ev_valid = 0;
    @(negedge clk);
    check("rel_ready", ev_ready, 1);

    // Fill
    send_wait(1, 52, 0);
    send_wait(1, 26, 0);
    send_wait(1, 100, 0);
    send_wait(1, 200, 0);
    pv = {12'd200, 12'd100, 12'd26, 12'd52};
    check("fill_pitch", v_pitch, pv);
    check("fill_ena", v_ena, 4'hf);
    check("fill_wave", v_wave, 0);
    check("fill_nosteal", steal_cnt, 0);

    // Steal the oldest voice (voice 0)
    send_wait(1, 300, 3);
    check("steal_pitch0", v_pitch[11:0], 12'd300);
    check("steal_wave0", v_wave[1:0], 2'd3);
    check("steal_count", steal_cnt, 1);

    // Retrigger and release
    send_wait(1, 26, 2);
    check("retrig_wave1", v_wave[3:2], 2'd2);
    check("retrig_nosteal", steal_cnt, 1);
    send_wait(0, 100, 0);
    check("off_ena2", v_ena[2], 0);
    check("off_pitch2", v_pitch[35:24], 12'd100);
    send_wait(1, 400, 1);
    check("reuse_ena2", v_ena[2], 1);
    check("reuse_pitch2", v_pitch[35:24], 12'd400);
    send_wait(0, 999, 0);
    pv = {12'd200, 12'd400, 12'd26, 12'd300};
    check("nomatch_pitch", v_pitch, pv);
    check("nomatch_ena", v_ena, 4'hf);

    // Panic during MATCH drops the event
    @(posedge clk); #1;
    ev_valid = 1; ev_on = 1; ev_pitch = 12'd700; ev_wave = 1;
    @(negedge clk);
    check("pan_ready_idle", ev_ready, 1);
    @(posedge clk); #1;
    ev_valid = 0; all_off = 1;
    @(negedge clk);
    check("pan_ready_busy", ev_ready, 0);
    @(posedge clk); #1;
    all_off = 0;
    @(negedge clk);
    check("pan_ready_after", ev_ready, 1);
    repeat (2) @(negedge clk);
    check("pan_ena", v_ena, 0);
    check("pan_pitch", v_pitch, pv);
    check("pan_nosteal", steal_cnt, 1);

    // all_off in the same cycle as an offered event
    acc_before = accept_cnt;
    @(posedge clk); #1;
    all_off = 1; ev_valid = 1; ev_on = 1; ev_pitch = 12'd800;
    @(negedge clk);
    check("same_cycle_ready", ev_ready, 0);
    @(posedge clk); #1;
    all_off = 0; ev_valid = 0;
    repeat (4) @(negedge clk);
    check("same_cycle_drop", accept_cnt, acc_before);
    check("same_cycle_ena", v_ena, 0);

    // Back-to-back: ev_valid held for 12 cycles
    @(posedge clk); #1;
    ev_valid = 1; ev_on = 1; ev_pitch = 12'd500; ev_wave = 2;
    got = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      a = ev_ready;
      @(posedge clk); #1;
      if (a) begin
        got++;
        ev_pitch = ev_pitch + 12'd1;
      end
    end
    ev_valid = 0;
    check("b2b_count", got, 4);
    repeat (3) @(posedge clk);
    @(negedge clk);
    pv = {12'd503, 12'd502, 12'd501, 12'd500};
    check("b2b_pitch", v_pitch, pv);
    check("b2b_ena", v_ena, 4'hf);

    // Further steals exercise the rank bookkeeping
    send_wait(1, 600, 0);
    check("steal2_pitch0", v_pitch[11:0], 12'd600);
    check("steal2_count", steal_cnt, 2);
    send_wait(1, 601, 1);
    check("steal3_pitch1", v_pitch[23:12], 12'd601);
    check("steal3_count", steal_cnt, 3);

    // Reset mid-operation discards the pending event
    @(posedge clk); #1;
    ev_valid = 1; ev_on = 1; ev_pitch = 12'd900; ev_wave = 0;
    @(negedge clk);
    @(posedge clk); #1;
    ev_valid = 0; rst = 0;
    @(posedge clk); #1;
    rst = 1;
    repeat (4) @(negedge clk);
    check("midrst_ena", v_ena, 0);
    check("midrst_pitch", v_pitch, 0);
    check("midrst_ready", ev_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
